keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//  4x4 hex matrix-keypad scanner and debouncer: the input-side counterpart of the 4-digit 7-seg display driver.
//  Scans the rows with a rotating one-cold strobe, reads the active-low columns and debounces over whole scan frames.
//  Each accepted key is shifted into a 16-bit entry register that drives the display's data input.
// PARAMETERS
//  SCAN_DIV        1000  CLK cycles per row slot (>=2); one frame = 4*SCAN_DIV cycles
//  DEBOUNCE_SCANS  4     consecutive identical frames needed to accept a press or a release (1..15)
// PORTS
//  CLK          in   1   system clock; all logic on posedge
//  clr_n        in   1   synchronous reset, active-low
//  col_in       in   4   keypad columns, active-low (pulled up), already synchronised upstream
//  clear_entry  in   1   one-cycle pulse: zero entry_data
//  row_ctrl     out  4   row strobe, one-cold, active-low
//  key_valid    out  1   one-cycle pulse per accepted key
//  key_code     out  4   code of the last accepted key, held until the next one
//  entry_data   out  16  entry register, newest key in [3:0]
// BEHAVIOUR
//  Reset (clr_n=0 at posedge, any time incl. mid-frame): row_ctrl=4'b1110, slot counter=0, key_valid=0,
//   key_code=0, entry_data=0, FSM=IDLE, frame counter=0, frame accumulator cleared.
//  Scan: row_ctrl rotates 1110->1101->1011->0111->1110, advancing every SCAN_DIV cycles.
//   Row index r = bit position of the 0 in row_ctrl.
//  Sampling: col_in sampled only in the last cycle of each row slot. frame_end = last cycle of row 3's slot.
//  Frame class from the 4 samples: NONE (all cols 1111), ONE (exactly one 0 bit over the whole frame),
//   MULTI (more than one 0 bit). For ONE: code = 4*r + c, c = bit index of the 0 in col_in (0..15).
//  FSM, evaluated only at frame_end; cnt is a 4-bit counter:
//   IDLE:   ONE -> CAND, cand=code, cnt=1. NONE/MULTI -> stay.
//   CAND:   ONE with same code -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> ACCEPT.
//           ONE with different code -> cand=new code, cnt=1. NONE/MULTI -> IDLE, cnt=0.
//   ACCEPT: on the next cycle, key_valid=1 for exactly one cycle, key_code=cand,
//           entry_data={entry_data[11:0],cand}; FSM -> HELD, cnt=0.
//   HELD:   NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE. ONE/MULTI -> cnt=0 (still held).
//  Latency: key_valid is high in the cycle after the frame_end that completes the DEBOUNCE_SCANS-th matching frame.
//  DEBOUNCE_SCANS=1: the first ONE frame goes IDLE->ACCEPT directly.
//  Auto-repeat: none. A held key yields exactly one key_valid, however long it is held.
//  clear_entry: entry_data=0 on the next cycle. If it coincides with an accept, entry_data={12'h000,cand}.
//  Overflow: entries beyond 4 digits shift the oldest nibble out of [15:12]; no flag is raised.
//  key_valid is registered and is never high in two consecutive cycles.
// STRUCTURE
//  Shared include keypad_defs.vh: FSM state encodings (IDLE/CAND/ACCEPT/HELD), ROW_INIT=4'b1110,
//   frame-class encodings (NONE/ONE/MULTI), KEY_W=4.
//  Sub-module row_scanner: SCAN_DIV slot counter, one-cold row rotation, sample strobe, frame_end strobe.
//  Top level: frame accumulator/classifier, debounce FSM, entry shift register.
// TESTING  (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3; frame = 16 cycles)
//  1. Release clr_n, no key -> row_ctrl sequence 1110,1101,1011,0111 with 4 cycles each; entry_data stays 16'h0000; no key_valid.
//  2. Hold row1/col2 (code 6) for 5 frames -> one key_valid pulse, 1 cycle after the 3rd frame_end;
//     key_code=4'h6, entry_data=16'h0006.
//  3. Bounce: code 6 present 2 frames, absent 1 frame, present 3 frames -> exactly one pulse,
//     after the 3rd frame of the final run.
//  4. Enter A,B,C,D,E, each followed by 3 release frames -> entry_data 000A,00AB,0ABC,ABCD, then BCDE after the 5th key.
//  5. Hold codes 1 and 5 together for 6 frames -> no key_valid. clear_entry pulsed in an accept cycle for code 9 -> entry_data=16'h0009.
//  6. Drop clr_n mid-frame during CAND -> next cycle row_ctrl=1110, key_valid=0, entry_data=0; the held key needs 3 fresh frames to be accepted.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad scanner: FSM states, frame classes,
// row strobe start value and small column-decoding helpers.
package keypad_entry_pkg;

    localparam int         KEY_W    = 4;
    localparam logic [3:0] ROW_INIT = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAND   = 2'd1,
        ACCEPT = 2'd2,
        HELD   = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_ONE   = 2'd1,
        FC_MULTI = 2'd2
    } frame_class_t;

    function automatic logic [2:0] zero_count(input logic [3:0] cols);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~cols[i]};
        end
        return n;
    endfunction

    // Lowest-numbered low column; only meaningful when exactly one is low.
    function automatic logic [1:0] zero_index(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] shift_in(input logic [15:0] entry,
                                             input logic [KEY_W-1:0] code,
                                             input logic clr);
        return clr ? {12'h000, code} : {entry[11:0], code};
    endfunction

endpackage

// File: rtl/keypad_entry_row_scanner.sv
// Row strobe generator: SCAN_DIV-cycle slots, rotating one-cold row drive,
// a sample strobe in the last cycle of each slot and a frame_end strobe on row 3.
module keypad_entry_row_scanner
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       CLK,
    input  logic       clr_n,
    output logic [3:0] row_ctrl,
    output logic [1:0] row_idx,
    output logic       sample,
    output logic       frame_end
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] slot_cnt;

    always_ff @(posedge CLK) begin
        if (!clr_n) begin
            slot_cnt <= '0;
            row_idx  <= 2'd0;
            row_ctrl <= ROW_INIT;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            row_idx  <= row_idx + 2'd1;
            row_ctrl <= {row_ctrl[2:0], row_ctrl[3]};
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign sample    = (slot_cnt == SLOT_LAST);
    assign frame_end = sample && (row_idx == 2'd3);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner/debouncer feeding a 4-digit entry shift register.
// Columns are classified per frame; a debounce FSM accepts one key per press.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             CLK,
    input  logic             clr_n,
    input  logic [3:0]       col_in,
    input  logic             clear_entry,
    output logic [3:0]       row_ctrl,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic [15:0]      entry_data
);

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [1:0]       row_idx;
    logic             sample;
    logic             frame_end;

    logic [1:0]       acc_zeros;   // saturates at 2: anything above one is MULTI
    logic [3:0]       acc_code;
    logic [2:0]       samp_zeros;
    logic [2:0]       tot_zeros;
    logic [3:0]       samp_code;
    frame_class_t     fclass;
    logic [3:0]       fcode;

    kp_state_t        state;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] cand;

    keypad_entry_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .CLK       (CLK),
        .clr_n     (clr_n),
        .row_ctrl  (row_ctrl),
        .row_idx   (row_idx),
        .sample    (sample),
        .frame_end (frame_end)
    );

    assign samp_zeros = zero_count(col_in);
    assign tot_zeros  = {1'b0, acc_zeros} + samp_zeros;
    assign samp_code  = {row_idx, zero_index(col_in)};

    // Classification includes the row-3 sample taken in the frame_end cycle itself.
    always_comb begin
        fclass = FC_NONE;
        fcode  = acc_code;
        if (tot_zeros > 3'd1) begin
            fclass = FC_MULTI;
        end else if (tot_zeros == 3'd1) begin
            fclass = FC_ONE;
            fcode  = (acc_zeros == 2'd0) ? samp_code : acc_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (!clr_n || frame_end) begin
            acc_zeros <= 2'd0;
            acc_code  <= 4'd0;
        end else if (sample) begin
            acc_zeros <= (tot_zeros > 3'd1) ? 2'd2 : tot_zeros[1:0];
            if (acc_zeros == 2'd0 && samp_zeros == 3'd1) acc_code <= samp_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (!clr_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cand       <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            entry_data <= 16'h0000;
        end else begin
            key_valid <= 1'b0;
            if (clear_entry) entry_data <= 16'h0000;
            case (state)
                IDLE: begin
                    if (frame_end && fclass == FC_ONE) begin
                        cand <= fcode;
                        if (DB == 4'd1) begin
                            state      <= ACCEPT;
                            cnt        <= 4'd0;
                            key_valid  <= 1'b1;
                            key_code   <= fcode;
                            entry_data <= shift_in(entry_data, fcode, clear_entry);
                        end else begin
                            state <= CAND;
                            cnt   <= 4'd1;
                        end
                    end
                end
                CAND: begin
                    if (frame_end) begin
                        if (fclass == FC_ONE && fcode == cand) begin
                            if (cnt + 4'd1 >= DB) begin
                                state      <= ACCEPT;
                                cnt        <= 4'd0;
                                key_valid  <= 1'b1;
                                key_code   <= cand;
                                entry_data <= shift_in(entry_data, cand, clear_entry);
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else if (fclass == FC_ONE) begin
                            cand <= fcode;
                            cnt  <= 4'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                end
                // Outputs were registered on entry; a clear landing in the pulse cycle keeps the new key.
                ACCEPT: begin
                    state <= HELD;
                    cnt   <= 4'd0;
                    if (clear_entry) entry_data <= {12'h000, cand};
                end
                HELD: begin
                    if (frame_end) begin
                        if (fclass == FC_NONE) begin
                            if (cnt + 4'd1 >= DB) begin
                                state <= IDLE;
                                cnt   <= 4'd0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a run-length reference model.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    logic        CLK = 1'b0;
    logic        clr_n = 1'b0;
    logic        clear_entry = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  col_in;
    logic [3:0]  row_ctrl;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_data;

    int n_cmp = 0;
    int n_err = 0;

    keypad_entry #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .CLK         (CLK),
        .clr_n       (clr_n),
        .col_in      (col_in),
        .clear_entry (clear_entry),
        .row_ctrl    (row_ctrl),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .entry_data  (entry_data)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: key 4*r+c shorts row r to column c.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_ctrl[r] && keys[4*r+c]) col_in[c] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset, recorded column samples, run lengths.
    int          t = 0;
    int          cyc = 0;
    logic [3:0]  samp [4];
    int          run_code = 0;
    int          run_len = 0;
    int          none_len = 0;
    bit          held = 0;
    bit          armed = 0;
    logic        m_kv = 1'b0;
    logic [3:0]  m_code = 4'h0;
    logic [15:0] m_entry = 16'h0000;

    task automatic model_frame();
        int zeros;
        int code;
        zeros = 0;
        code = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!samp[r][c]) begin
                    zeros++;
                    code = 4 * r + c;
                end
        if (held) begin
            if (zeros == 0) begin
                none_len++;
                if (none_len >= DB) begin
                    held = 0;
                    none_len = 0;
                end
            end else begin
                none_len = 0;
            end
        end else if (zeros == 1) begin
            if (run_len > 0 && code == run_code) run_len++;
            else begin
                run_code = code;
                run_len = 1;
            end
            if (run_len >= DB) begin
                m_kv = 1'b1;
                m_code = 4'(code);
                m_entry = {m_entry[11:0], 4'(code)};
                held = 1;
                run_len = 0;
                none_len = 0;
            end
        end else begin
            run_len = 0;
        end
    endtask

    always @(posedge CLK) begin
        bit was_kv;
        if (!clr_n) begin
            t = 0;
            cyc = 0;
            run_len = 0;
            none_len = 0;
            held = 0;
            m_kv = 1'b0;
            m_code = 4'h0;
            m_entry = 16'h0000;
            armed = 1;
        end else begin
            was_kv = m_kv;
            m_kv = 1'b0;
            if (clear_entry) m_entry = was_kv ? {12'h000, m_code} : 16'h0000;
            if (t % SD == SD - 1) begin
                samp[(t / SD) % 4] = col_in;
                if ((t / SD) % 4 == 3) model_frame();
            end
            t++;
            cyc++;
        end
    end

    int kv_count = 0;
    int kv_cyc = -1;

    always @(negedge CLK) begin
        logic [3:0] exp_row;
        if (armed) begin
            exp_row = ~(4'b0001 << ((t / SD) % 4));
            check("row_ctrl", {12'h0, row_ctrl}, {12'h0, exp_row});
            check("key_valid", {15'h0, key_valid}, {15'h0, m_kv});
            check("key_code", {12'h0, key_code}, {12'h0, m_code});
            check("entry_data", entry_data, m_entry);
            if (key_valid) begin
                kv_count++;
                kv_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        clr_n = 1'b0;
        keys = 16'h0000;
        clear_entry = 1'b0;
        @(negedge CLK);
        clr_n = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n * FR) @(negedge CLK);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  row_tab [4];
        logic [15:0] ent_tab [5];
        int k0;
        bit seen;

        row_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        ent_tab = '{16'h000A, 16'h00AB, 16'h0ABC, 16'hABCD, 16'hBCDE};

        // 1: idle scan
        do_reset();
        k0 = kv_count;
        for (int i = 0; i < FR; i++) begin
            #1 check("t1_row_seq", {12'h0, row_ctrl}, {12'h0, row_tab[i / SD]});
            @(negedge CLK);
        end
        #1 check("t1_entry", entry_data, 16'h0000);
        check("t1_no_kv", 16'(kv_count - k0), 16'd0);

        // 2: steady press of code 6
        do_reset();
        k0 = kv_count;
        keys = 16'h0040;
        frames(5);
        #1 check("t2_pulses", 16'(kv_count - k0), 16'd1);
        check("t2_latency", 16'(kv_cyc), 16'd48);
        check("t2_code", {12'h0, key_code}, 16'h0006);
        check("t2_entry", entry_data, 16'h0006);
        keys = 16'h0000;
        frames(3);

        // 3: bounce
        do_reset();
        k0 = kv_count;
        keys = 16'h0040; frames(2);
        keys = 16'h0000; frames(1);
        keys = 16'h0040; frames(4);
        #1 check("t3_pulses", 16'(kv_count - k0), 16'd1);
        check("t3_latency", 16'(kv_cyc), 16'd96);
        keys = 16'h0000;
        frames(3);

        // 4: five entries, overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            keys = 16'(1) << (10 + i);
            frames(3);
            keys = 16'h0000;
            frames(3);
            #1 check("t4_entry", entry_data, ent_tab[i]);
        end

        // 5: two keys, then clear during accept
        do_reset();
        k0 = kv_count;
        keys = 16'h0022;
        frames(6);
        #1 check("t5_multi_no_kv", 16'(kv_count - k0), 16'd0);
        check("t5_multi_entry", entry_data, 16'h0000);
        keys = 16'h0020; frames(3);
        keys = 16'h0000; frames(3);
        keys = 16'h0200;
        seen = 0;
        for (int i = 0; i < 6 * FR && !seen; i++) begin
            @(negedge CLK);
            #1 if (key_valid) seen = 1;
        end
        check("t5_kv_seen", {15'h0, seen}, 16'h0001);
        clear_entry = 1'b1;
        @(negedge CLK);
        clear_entry = 1'b0;
        #1 check("t5_clear_accept", entry_data, 16'h0009);
        check("t5_code", {12'h0, key_code}, 16'h0009);
        keys = 16'h0000;
        frames(3);

        // 6: reset mid-frame while a candidate is being debounced
        do_reset();
        keys = 16'h0020; frames(3);
        keys = 16'h0000; frames(3);
        #1 check("t6_pre_entry", entry_data, 16'h0005);
        keys = 16'h0040;
        frames(2);
        repeat (8) @(negedge CLK);
        clr_n = 1'b0;
        @(negedge CLK);
        clr_n = 1'b1;
        #1 check("t6_row", {12'h0, row_ctrl}, 16'h000E);
        check("t6_kv", {15'h0, key_valid}, 16'h0000);
        check("t6_entry", entry_data, 16'h0000);
        k0 = kv_count;
        frames(3);
        #1 check("t6_pulses", 16'(kv_count - k0), 16'd1);
        check("t6_latency", 16'(kv_cyc), 16'd48);
        keys = 16'h0000;
        frames(3);

        // Randomized phase
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int sel;
            int hold;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      keys = 16'(1) << $urandom_range(0, 15);
            else if (sel <= 7) keys = 16'h0000;
            else               keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            hold = int'($urandom_range(1, 5)) * FR;
            if ($urandom_range(0, 3) == 0) hold += int'($urandom_range(1, FR - 1));
            for (int c = 0; c < hold; c++) begin
                clear_entry = ($urandom_range(0, 63) == 0);
                @(negedge CLK);
            end
            clear_entry = 1'b0;
        end
        keys = 16'h0000;
        frames(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
